// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped timer/counter.
// Holds the FSM state encoding, register offsets (Addr[3:2]), CTRL bit
// positions and the counting-mode codes.
package tc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StCnt  = 2'b10,
    StInt  = 2'b11
  } tc_state_e;

  // Register offsets as seen on Addr[3:2]; 2'b11 is reserved.
  localparam logic [1:0] RegCtrl   = 2'b00;
  localparam logic [1:0] RegPreset = 2'b01;
  localparam logic [1:0] RegCount  = 2'b10;

  // CTRL layout: [0] enable, [2:1] mode, [3] interrupt mask.
  localparam int unsigned CtrlW       = 4;
  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;

  localparam logic [1:0] ModeOneShot    = 2'b00;
  localparam logic [1:0] ModeAutoReload = 2'b01;

  // Only 01 reloads; 10 and 11 fall back to one-shot behaviour.
  function automatic logic is_auto_reload(input logic [1:0] mode);
    return mode == ModeAutoReload;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer acting as a data-memory bus responder.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   Addr  - byte address; Addr[3:2] selects CTRL / PRESET / COUNT / reserved
//   WE    - write strobe for the selected register
//   Din   - store data
//   Dout  - combinational read of the selected register (old value on a write)
//   IRQ   - interrupt request, irq_flag gated by the CTRL interrupt mask
module timer_counter
  import tc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CtrlW-1:0] ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic             irq_flag_q;
  tc_state_e        state_q;

  logic [1:0] reg_sel;
  logic       ctrl_wr;
  logic       preset_wr;
  logic       enable;
  logic       auto_reload;

  assign reg_sel     = Addr[3:2];
  assign ctrl_wr     = WE && (reg_sel == RegCtrl);
  assign preset_wr   = WE && (reg_sel == RegPreset);
  assign enable      = ctrl_q[CtrlEnBit];
  assign auto_reload = is_auto_reload(ctrl_q[CtrlModeMsb:CtrlModeLsb]);

  // Byte-lane and upper address bits are decoded externally.
  logic unused_addr;
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= StIdle;
    end else begin
      if (preset_wr) begin
        preset_q <= Din[CNT_W-1:0];
      end

      case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!enable) begin
            state_q <= StIdle;  // COUNT stays frozen
          end else if (count_q > CntOne) begin
            count_q <= count_q - CntOne;
          end else begin
            count_q    <= '0;
            irq_flag_q <= 1'b1;
            state_q    <= StInt;
          end
        end
        StInt: begin
          if (auto_reload) begin
            irq_flag_q <= 1'b0;
            state_q    <= StLoad;
          end else begin
            ctrl_q[CtrlEnBit] <= 1'b0;
            state_q           <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Placed last so a software CTRL write overrides the INT-state
      // enable clear and any flag set in the same cycle.
      if (ctrl_wr) begin
        ctrl_q     <= Din[CtrlW-1:0];
        irq_flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    Dout = '0;
    case (reg_sel)
      RegCtrl:   Dout[CtrlW-1:0] = ctrl_q;
      RegPreset: Dout[CNT_W-1:0] = preset_q;
      RegCount:  Dout[CNT_W-1:0] = count_q;
      default:   Dout = '0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[CtrlImBit];

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  localparam logic [31:0] ACtrl = 32'h0;
  localparam logic [31:0] APre  = 32'h4;
  localparam logic [31:0] ACnt  = 32'h8;
  localparam logic [31:0] ARsv  = 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] ed, input logic ei);
    vec_t v;
    v.we = w; v.addr = a; v.din = d; v.exp_dout = ed; v.exp_irq = ei;
    return v;
  endfunction

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_empty: no expected entry for sampled output");
      return;
    end
    e = sb.pop_front();
    total++;
    if (Dout !== e.dout) begin
      bad++;
      $display("FAIL %s dout: got %08h expected %08h", e.nm, Dout, e.dout);
    end
    total++;
    if (IRQ !== e.irq) begin
      bad++;
      $display("FAIL %s irq: got %0b expected %0b", e.nm, IRQ, e.irq);
    end
  endtask

  // One bus cycle: drive at the falling edge, sample 1 ns later (pre-write values).
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input logic ei, input string nm);
    exp_t e;
    @(negedge clk);
    WE = w; Addr = a; Din = d;
    e.nm = nm; e.dout = ed; e.irq = ei;
    sb.push_back(e);
    #1;
    check_front();
  endtask

  initial begin
    int p;
    logic [31:0] ec;
    logic        ei;

    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset reads, ignored writes, then a one-shot run with PRESET = 5.
    vecs.push_back(mk(0, ACtrl, 0, 0, 0));
    vecs.push_back(mk(0, APre,  0, 0, 0));
    vecs.push_back(mk(0, ACnt,  0, 0, 0));
    vecs.push_back(mk(0, ARsv,  0, 0, 0));
    vecs.push_back(mk(1, ARsv,  32'hFFFF_FFFF, 0, 0));
    vecs.push_back(mk(1, ACnt,  32'h1234, 0, 0));
    vecs.push_back(mk(0, ACnt,  0, 0, 0));
    vecs.push_back(mk(0, ARsv,  0, 0, 0));
    vecs.push_back(mk(1, APre,  5, 0, 0));
    vecs.push_back(mk(0, APre,  0, 5, 0));
    vecs.push_back(mk(1, ACtrl, 32'h9, 0, 0));   // E0
    vecs.push_back(mk(0, ACnt,  0, 0, 0));       // after E0
    vecs.push_back(mk(0, ACtrl, 0, 32'h9, 0));   // after E1 (LOAD)
    vecs.push_back(mk(0, ACnt,  0, 5, 0));       // after E2
    vecs.push_back(mk(0, ACnt,  0, 4, 0));
    vecs.push_back(mk(0, ACnt,  0, 3, 0));
    vecs.push_back(mk(0, ACnt,  0, 2, 0));
    vecs.push_back(mk(0, ACnt,  0, 1, 0));
    vecs.push_back(mk(0, ACnt,  0, 0, 1));       // after E7: INT
    vecs.push_back(mk(0, ACtrl, 0, 32'h8, 1));   // after E8: enable cleared
    vecs.push_back(mk(0, ACnt,  0, 0, 1));
    vecs.push_back(mk(1, ACtrl, 32'h8, 32'h8, 1));
    vecs.push_back(mk(0, ACtrl, 0, 32'h8, 0));
    vecs.push_back(mk(0, ACnt,  0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp_dout, vecs[i].exp_irq,
          $sformatf("vec[%0d]", i));
    end

    // Auto-reload, PRESET = 3: period 5, one-cycle IRQ pulse.
    cyc(1, APre, 3, 5, 0, "ar_pre");
    cyc(1, ACtrl, 32'hB, 32'h8, 0, "ar_ctrl");
    for (int k = 0; k <= 16; k++) begin
      if (k < 2) begin
        ec = 0; ei = 0;
      end else begin
        p = (k - 2) % 5;
        ec = (p == 4) ? 32'd0 : 32'(3 - p);
        ei = (p == 3);
      end
      cyc(0, ACnt, 0, ec, ei, $sformatf("ar_k%0d", k));
    end
    cyc(1, ACtrl, 0, 32'hB, 0, "ar_stop");
    cyc(0, ACnt, 0, 2, 0, "ar_hold0");
    cyc(0, ACnt, 0, 2, 0, "ar_hold1");
    cyc(0, ACnt, 0, 2, 0, "ar_hold2");

    // PRESET = 0: INT one cycle after LOAD.
    cyc(1, APre, 0, 3, 0, "p0_pre");
    cyc(1, ACtrl, 32'h9, 0, 0, "p0_ctrl");
    cyc(0, ACnt, 0, 2, 0, "p0_e0");
    cyc(0, ACnt, 0, 2, 0, "p0_e1");
    cyc(0, ACnt, 0, 0, 0, "p0_e2");
    cyc(0, ACnt, 0, 0, 1, "p0_e3");
    cyc(0, ACtrl, 0, 32'h8, 1, "p0_e4");
    cyc(1, ACtrl, 0, 32'h8, 1, "p0_clr");
    cyc(0, ACtrl, 0, 0, 0, "p0_after");

    // Mid-count disable, PRESET change, restart.
    cyc(1, APre, 10, 0, 0, "mc_pre");
    cyc(1, ACtrl, 32'h9, 0, 0, "mc_ctrl");
    cyc(0, ACnt, 0, 0, 0, "mc_e0");
    cyc(0, ACnt, 0, 0, 0, "mc_e1");
    cyc(0, ACnt, 0, 10, 0, "mc_e2");
    cyc(0, ACnt, 0, 9, 0, "mc_e3");
    cyc(1, ACtrl, 0, 32'h9, 0, "mc_stop");
    cyc(0, ACnt, 0, 7, 0, "mc_hold0");
    cyc(0, ACnt, 0, 7, 0, "mc_hold1");
    cyc(0, ACnt, 0, 7, 0, "mc_hold2");
    cyc(1, APre, 20, 10, 0, "mc_pre20");
    cyc(1, ACtrl, 32'h9, 0, 0, "mc_reen");
    cyc(0, ACnt, 0, 7, 0, "mc_r0");
    cyc(0, ACnt, 0, 7, 0, "mc_r1");
    cyc(0, ACnt, 0, 20, 0, "mc_r2");
    cyc(1, APre, 2, 20, 0, "mc_pre_in_cnt");
    cyc(0, ACnt, 0, 18, 0, "mc_cnt_unaffected");
    cyc(0, APre, 0, 2, 0, "mc_pre_read");
    cyc(1, ACtrl, 0, 32'h9, 0, "mc_stop2");
    cyc(0, ACnt, 0, 15, 0, "mc_s0");
    cyc(0, ACnt, 0, 15, 0, "mc_s1");

    // CTRL write on the INT cycle wins over the enable clear.
    cyc(1, ACtrl, 32'h9, 0, 0, "cf_ctrl");
    cyc(0, ACnt, 0, 15, 0, "cf_e0");
    cyc(0, ACnt, 0, 15, 0, "cf_e1");
    cyc(0, ACnt, 0, 2, 0, "cf_e2");
    cyc(0, ACnt, 0, 1, 0, "cf_e3");
    cyc(1, ACtrl, 32'h9, 32'h9, 1, "cf_int_wr");
    cyc(0, ACtrl, 0, 32'h9, 0, "cf_ctrl_kept");
    cyc(0, ACnt, 0, 0, 0, "cf_load");
    cyc(0, ACnt, 0, 2, 0, "cf_restart");
    cyc(0, ACnt, 0, 1, 0, "cf_dec");

    // Reset mid-count beats a simultaneous write.
    @(negedge clk);
    reset = 1'b1; WE = 1'b1; Addr = APre; Din = 32'h55;
    @(negedge clk);
    reset = 1'b0; WE = 1'b0;
    #1;
    cyc(0, ACtrl, 0, 0, 0, "rst_ctrl");
    cyc(0, APre, 0, 0, 0, "rst_pre");
    cyc(0, ACnt, 0, 0, 0, "rst_cnt");
    cyc(0, ARsv, 0, 0, 0, "rst_rsv");
    cyc(0, ACnt, 0, 0, 0, "rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped timer/counter that answers the pipeline's data-memory load/store port as a bus responder, in place of or beside the data memory. The CPU writes control and preset words and reads back the live count; the block counts down on every clock and raises an interrupt request when the count expires. External address decode selects this block and drives its write strobe. Read data is returned combinationally in the same cycle as the access, matching data-memory load timing.

## Interface
Parameters:
- CNT_W, 32, width of PRESET and COUNT; upper bits of Dout read 0 when CNT_W < 32.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Addr  in  32  byte address. Only Addr[3:2] is used: 00 = CTRL, 01 = PRESET, 10 = COUNT, 11 = reserved (reads 0, writes ignored).
- WE  in  1  write strobe for the selected register, one cycle per store.
- Din  in  32  store data.
- Dout  out  32  combinational read of the register selected by Addr.
- IRQ  out  1  interrupt request, registered.

## Operation
- CTRL fields:
  - [0] Enable.
  - [2:1] Mode: 00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00.
  - [3] IM, the interrupt mask.
  - [31:4] read 0.
- PRESET: read/write.
- COUNT: read-only; writes are ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: when Enable=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if Enable=0, go to IDLE with COUNT held. Else if COUNT > 1, COUNT <= COUNT-1. Else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, mode 00: clear Enable; go to IDLE; irq_flag stays 1.
  - INT, mode 01: clear irq_flag; go to LOAD.
- IRQ = irq_flag & IM.
- Any CTRL write clears irq_flag.
- A CTRL write in the same cycle as the INT-state Enable clear wins, so CTRL takes the written value.
- A PRESET write during CNT does not change COUNT. It takes effect at the next LOAD.
- PRESET = 0 or 1: CNT goes straight to INT on its first cycle with COUNT = 0.
- A CTRL write with Enable=0 during CNT freezes COUNT. Re-enabling goes IDLE -> LOAD, so counting restarts from PRESET.

## Timing
- Reset: CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state IDLE, IRQ = 0. Dout then reads 0 for all addresses.
- Reset asserted mid-count wins over every write and FSM action in that cycle.
- Writes take effect at the edge that samples WE=1. A read in the same cycle returns the old value; there is no write-through.
- Edge E0 writes Enable=1 with PRESET = N >= 1:
  - E1: enter LOAD.
  - E2: COUNT = N, enter CNT.
  - After E(k+2): COUNT = N-k.
  - E(N+2): COUNT = 0, enter INT, IRQ rises if IM = 1.
- Mode 00: IRQ stays high until a CTRL write.
- Mode 01: IRQ is high for exactly 1 cycle, and the period is N+2 cycles.

## Structure
- Shared package tc_pkg holds:
  - state encoding (IDLE/LOAD/CNT/INT);
  - register offsets 2'b00/2'b01/2'b10;
  - CTRL bit positions;
  - mode codes.
- Single module, no sub-module; register file and FSM are written inline.

## Test plan
- Reset, then read Addr 0x0/0x4/0x8/0xC -> all return 0; IRQ = 0.
- PRESET = 5, CTRL = 0x9 (enable, mode 00, IM) -> COUNT reads 5,4,3,2,1,0 on consecutive cycles from E2. IRQ rises at E7 and holds. CTRL reads 0x8 after E8. Writing CTRL = 0x8 drops IRQ next cycle.
- PRESET = 3, CTRL = 0xB (auto-reload, IM) -> IRQ is a 1-cycle pulse every 5 cycles; COUNT sequence 3,2,1,0,(LOAD),3,...
- PRESET = 0, enable with mode 00 -> INT is reached one cycle after LOAD; IRQ rises at E3.
- Mid-count: write CTRL = 0 when COUNT = 7 -> COUNT holds 7. Write PRESET = 20 and then CTRL = 0x9 -> counting restarts from 20.
- Same-cycle conflict: CTRL = 0x9 written on the INT cycle -> Enable stays 1, IRQ clears, and a fresh count starts from PRESET.
